// File: rtl/stopwatch_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_fsm
// Brief    : Key debounce, press/long-press detection and stopwatch run/mode FSM
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl_fsm #(
  parameter int N_KEYS      = 2,
  parameter int TICK_W      = 10,
  parameter int DEB_SAMPLES = 4,
  parameter int LONG_TICKS  = 512,
  parameter int NUM_MODES   = 4,
  parameter int MODE_W      = 2
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [1:0]        ssflag,
  output logic [MODE_W-1:0] mode,
  output logic              lap_pulse,
  output logic              clear_pulse,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_level
);

  localparam int c_DEB_W  = $clog2(DEB_SAMPLES + 1);
  localparam int c_HOLD_W = $clog2(LONG_TICKS + 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RUN   = 2'd2,
    ST_MODE  = 2'd3
  } state_t;

  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;
  logic [N_KEYS-1:0]  r_sync1;
  logic [N_KEYS-1:0]  r_sync2;
  logic [N_KEYS-1:0]  w_pressed;
  logic [c_DEB_W-1:0] r_deb_cnt [N_KEYS];
  logic [N_KEYS-1:0]  r_level_d;
  logic               w_k1_rise;
  logic               w_k1_fall;
  logic [c_HOLD_W-1:0] r_hold;
  logic               r_long_fired;
  logic               r_long_evt;
  logic               r_short_evt;
  state_t             r_state;

  assign w_tick    = &r_tick_cnt;
  assign w_pressed = ~r_sync2;
  assign w_k1_rise = key_level[1] & ~r_level_d[1];
  assign w_k1_fall = ~key_level[1] & r_level_d[1];
  assign ssflag    = r_state;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_tick_cnt <= '0;
      r_sync1    <= '1;
      r_sync2    <= '1;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      r_sync1    <= KEY;
      r_sync2    <= r_sync1;
    end
  end

  // A level flips only after DEB_SAMPLES consecutive ticks disagreeing with it.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_KEYS; i++) r_deb_cnt[i] <= '0;
      key_level <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (w_pressed[i] != key_level[i]) begin
          if (r_deb_cnt[i] == c_DEB_W'(DEB_SAMPLES - 1)) begin
            key_level[i] <= ~key_level[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + c_DEB_W'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_level_d <= '0;
      key_press <= '0;
    end else begin
      r_level_d <= key_level;
      key_press <= key_level & ~r_level_d;
    end
  end

  // Hold counter saturates, so long_evt can fire at most once per press.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_hold       <= '0;
      r_long_fired <= 1'b0;
      r_long_evt   <= 1'b0;
      r_short_evt  <= 1'b0;
    end else begin
      r_long_evt  <= 1'b0;
      r_short_evt <= w_k1_fall & ~r_long_fired;
      if (w_k1_rise) begin
        r_hold       <= '0;
        r_long_fired <= 1'b0;
      end else if (w_tick && key_level[1] && r_hold != c_HOLD_W'(LONG_TICKS)) begin
        r_hold <= r_hold + c_HOLD_W'(1);
        if (r_hold == c_HOLD_W'(LONG_TICKS - 1) && !r_long_fired) begin
          r_long_evt   <= 1'b1;
          r_long_fired <= 1'b1;
        end
      end
    end
  end

  // Key 0 has priority; a coincident key 1 event is dropped.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state     <= ST_STOP;
      mode        <= '0;
      lap_pulse   <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      lap_pulse   <= 1'b0;
      clear_pulse <= 1'b0;
      if (key_press[0]) begin
        case (r_state)
          ST_STOP:  r_state <= ST_RUN;
          ST_RUN:   r_state <= ST_PAUSE;
          ST_PAUSE: r_state <= ST_RUN;
          default:  mode <= (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + MODE_W'(1);
        endcase
      end else if (r_short_evt) begin
        case (r_state)
          ST_RUN:  lap_pulse <= 1'b1;
          default: begin
            r_state     <= ST_STOP;
            clear_pulse <= 1'b1;
          end
        endcase
      end else if (r_long_evt && r_state != ST_MODE) begin
        r_state <= ST_MODE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl_fsm
// Brief    : Directed plus random key stimulus against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl_fsm;

  localparam int N_KEYS = 2;
  localparam int TICK_W = 2;
  localparam int DEB    = 3;
  localparam int LONG   = 8;
  localparam int NM     = 3;
  localparam int MODE_W = 2;
  localparam int TP     = 1 << TICK_W;

  logic              CLOCK_50 = 1'b0;
  logic              RST      = 1'b1;
  logic [N_KEYS-1:0] KEY      = '1;
  logic [1:0]        ssflag;
  logic [MODE_W-1:0] mode;
  logic              lap_pulse;
  logic              clear_pulse;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_level;

  stopwatch_ctrl_fsm #(
    .N_KEYS(N_KEYS), .TICK_W(TICK_W), .DEB_SAMPLES(DEB),
    .LONG_TICKS(LONG), .NUM_MODES(NM), .MODE_W(MODE_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .KEY(KEY), .ssflag(ssflag), .mode(mode),
    .lap_pulse(lap_pulse), .clear_pulse(clear_pulse),
    .key_press(key_press), .key_level(key_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the stopwatch rules stated over whole ticks and events.
  int m_phase = 0;
  bit [1:0] m_s1 = 2'b11, m_s2 = 2'b11;
  bit [1:0] m_lvl = 0, m_prev = 0, m_press = 0;
  int m_run[2] = '{0, 0};
  int m_held = 0;
  bit m_fired = 0, m_long = 0, m_short = 0, m_lap = 0, m_clr = 0;
  int m_state = 0;
  int m_mode = 0;

  always @(posedge CLOCK_50 or posedge RST) begin
    bit tick, k0, sh, lg, rise1, fall1;
    bit [1:0] lvl, prev, raw;
    if (RST) begin
      m_phase = 0; m_s1 = 2'b11; m_s2 = 2'b11;
      m_lvl = 0; m_prev = 0; m_press = 0; m_run = '{0, 0};
      m_held = 0; m_fired = 0; m_long = 0; m_short = 0;
      m_lap = 0; m_clr = 0; m_state = 0; m_mode = 0;
    end else begin
      tick  = (m_phase == TP - 1);
      lvl   = m_lvl;  prev = m_prev;  raw = m_s2;
      k0    = m_press[0];  sh = m_short;  lg = m_long;
      rise1 = lvl[1] && !prev[1];
      fall1 = !lvl[1] && prev[1];
      m_phase = (m_phase + 1) % TP;
      m_s2 = m_s1;  m_s1 = KEY;
      if (tick)
        for (int i = 0; i < 2; i++) begin
          m_run[i] = (!raw[i] != lvl[i]) ? m_run[i] + 1 : 0;
          if (m_run[i] == DEB) begin
            m_lvl[i] = !lvl[i];
            m_run[i] = 0;
          end
        end
      m_press = lvl & ~prev;
      m_prev  = lvl;
      m_short = fall1 && !m_fired;
      m_long  = 0;
      if (rise1) begin
        m_held = 0; m_fired = 0;
      end else if (tick && lvl[1] && m_held < LONG) begin
        m_held++;
        if (m_held == LONG && !m_fired) begin m_long = 1; m_fired = 1; end
      end
      m_lap = 0; m_clr = 0;
      if (k0) begin
        if (m_state == 3) m_mode = (m_mode + 1) % NM;
        else m_state = (m_state == 2) ? 1 : 2;
      end else if (sh) begin
        if (m_state == 2) m_lap = 1;
        else begin m_state = 0; m_clr = 1; end
      end else if (lg) begin
        m_state = 3;
      end
    end
  end

  int n_p0 = 0, n_lap = 0, n_clr = 0;

  always @(negedge CLOCK_50) begin
    logic [31:0] exp_v;
    exp_v = {22'b0, 2'(m_state), 2'(m_mode), m_lap, m_clr, m_press, m_lvl};
    check("model", {22'b0, ssflag, mode, lap_pulse, clear_pulse, key_press, key_level}, exp_v);
    check("lap_clr_excl", 32'(lap_pulse & clear_pulse), 0);
    if (key_press[0]) n_p0++;
    if (lap_pulse)    n_lap++;
    if (clear_pulse)  n_clr++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
    #1;
  endtask

  task automatic tap(input int k, input int low, input int high);
    KEY[k] = 1'b0;
    cyc(low);
    KEY[k] = 1'b1;
    cyc(high);
  endtask

  initial begin
    int b0, bl, bc;
    cyc(3);
    RST = 1'b0;

    b0 = n_p0; bl = n_lap; bc = n_clr;
    cyc(200);
    check("idle_ss", ssflag, 0);
    check("idle_mode", mode, 0);
    check("idle_strobes", n_p0 - b0 + n_lap - bl + n_clr - bc, 0);

    b0 = n_p0;
    tap(0, 40, 40);
    check("k0_one_press", n_p0 - b0, 1);
    check("stop_to_run", ssflag, 2);
    tap(0, 40, 40);
    check("run_to_pause", ssflag, 1);
    tap(0, 40, 40);
    check("pause_to_run", ssflag, 2);

    bl = n_lap; bc = n_clr;
    tap(1, 20, 40);
    check("run_lap", n_lap - bl, 1);
    check("run_lap_no_clr", n_clr - bc, 0);
    check("run_stays", ssflag, 2);
    tap(0, 40, 40);
    bc = n_clr;
    tap(1, 20, 40);
    check("pause_clear", n_clr - bc, 1);
    check("pause_to_stop", ssflag, 0);

    tap(0, 40, 40);
    bl = n_lap;
    tap(1, 60, 40);
    check("long_to_mode", ssflag, 3);
    check("long_no_lap", n_lap - bl, 0);
    tap(0, 40, 40);
    check("mode_1", mode, 1);
    tap(0, 40, 40);
    check("mode_2", mode, 2);
    tap(0, 40, 40);
    check("mode_wrap", mode, 0);
    tap(0, 40, 40);
    bc = n_clr;
    tap(1, 20, 40);
    check("mode_exit_stop", ssflag, 0);
    check("mode_exit_clr", n_clr - bc, 1);
    check("mode_retained", mode, 1);

    b0 = n_p0;
    tap(0, 6, 40);
    check("glitch_no_press", n_p0 - b0, 0);
    check("glitch_ss", ssflag, 0);
    KEY[0] = 1'b1; cyc(3); KEY[0] = 1'b0; cyc(3);
    KEY[0] = 1'b1; cyc(3);
    tap(0, 40, 40);
    check("bounce_one_press", n_p0 - b0, 1);
    check("bounce_run", ssflag, 2);

    KEY[0] = 1'b0;
    cyc(30);
    RST = 1'b1;
    #1;
    check("rst_ss_now", ssflag, 0);
    check("rst_level_now", key_level, 0);
    cyc(2);
    RST = 1'b0;
    b0 = n_p0;
    cyc(8);
    check("rst_no_spurious", n_p0 - b0, 0);
    cyc(30);
    check("rst_redebounce", n_p0 - b0, 1);
    check("rst_then_run", ssflag, 2);
    KEY[0] = 1'b1;
    cyc(40);

    for (int it = 0; it < 60; it++) begin
      KEY = 2'($urandom_range(0, 3));
      cyc(int'($urandom_range(1, 70)));
      if ($urandom_range(0, 14) == 0) begin
        RST = 1'b1;
        cyc(int'($urandom_range(1, 3)));
        RST = 1'b0;
      end
    end
    KEY = 2'b11;
    cyc(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl_fsm.md
Name: stopwatch_ctrl_fsm

Overview:
Parametrised next-generation start/stop/mode controller for the stopwatch/clock design.
- Takes raw active-low KEY inputs, synchronises and debounces them per key, and detects press/release/long-press events.
- Drives the stopwatch run state (ssflag) plus a mode index, lap strobe and clear strobe.
- Sits between the board pushbuttons and the stopwatch counter/display blocks.

Parameters:
N_KEYS, 2, number of KEY inputs debounced; must be >= 2; KEY[0] = start/pause, KEY[1] = lap/clear/mode; the rest are debounced only.
TICK_W, 10, sample tick period = 2^TICK_W clocks.
DEB_SAMPLES, 4, consecutive differing samples required to accept a key change (>= 1).
LONG_TICKS, 512, ticks KEY[1] must be held to produce a long press (>= 2).
NUM_MODES, 4, number of display modes (>= 1).
MODE_W, 2, width of mode output; must satisfy 2^MODE_W >= NUM_MODES.

Ports:
CLOCK_50  in  1  system clock
RST  in  1  asynchronous reset, active high
KEY  in  N_KEYS  raw pushbuttons, active low (0 = pressed)
ssflag  out  2  state: 0 STOP, 1 PAUSE, 2 RUN, 3 MODE
mode  out  MODE_W  current display mode index
lap_pulse  out  1  one-cycle strobe: lap captured
clear_pulse  out  1  one-cycle strobe: clear stopwatch
key_press  out  N_KEYS  one-cycle debounced press strobes, per key
key_level  out  N_KEYS  debounced level, 1 = pressed

Behaviour:
- Reset (async, RST=1) values: ssflag=0, mode=0, lap_pulse=0, clear_pulse=0, key_press=0, key_level=0, tick counter=0, debounce counts=0, hold counter=0, long-fired flag=0, synchronisers=1 (released).
- Sample tick: a free-running TICK_W-bit counter. The tick is high for one cycle when the counter is all ones, and the counter wraps to 0.
- Synchroniser: a 2-flop synchroniser per key. The debounce logic sees only the synchronised value.
- Debounce, per key, evaluated only on tick:
  - If the synced pressed-state differs from key_level, increment the count.
  - Otherwise clear the count.
  - When the count reaches DEB_SAMPLES, toggle key_level and clear the count.
- key_press[i] is high for one cycle on the clock after key_level[i] goes 0->1. The internal release event of key 1 likewise fires on 1->0.
- Long press (key 1 only):
  - The hold counter clears on the key 1 press.
  - On each tick while key_level[1]=1 it increments, saturating at LONG_TICKS.
  - long_evt fires for one cycle when the counter first reaches LONG_TICKS, and the long-fired flag is set.
  - short_evt fires on the key 1 release only if the long-fired flag is 0.
  - The long-fired flag clears on the next key 1 press.
- FSM transitions take effect on the clock edge after the event pulse. A pulse output is high exactly in that same cycle.
  - STOP: k0 press -> RUN. short_evt -> clear_pulse, stay STOP. long_evt -> MODE.
  - RUN: k0 press -> PAUSE. short_evt -> lap_pulse, stay RUN. long_evt -> MODE.
  - PAUSE: k0 press -> RUN. short_evt -> STOP with clear_pulse. long_evt -> MODE.
  - MODE: k0 press -> mode = (mode == NUM_MODES-1) ? 0 : mode+1, stay MODE. short_evt -> STOP with clear_pulse. long_evt -> ignored.
- Simultaneous k0 press and k1 event in the same cycle: k0 is acted on, the k1 event is dropped.
- Pulses never last more than one cycle. lap_pulse and clear_pulse are never high together.
- Keys 2..N_KEYS-1 drive only key_press and key_level.
- Glitches shorter than DEB_SAMPLES ticks produce no key_level change.
- An RST assertion at any time returns all state to reset values immediately. No event is generated on release of RST, even if a key is held. A held key must be debounced again after reset.

Test Plan:
Bench parameters: TICK_W=2, DEB_SAMPLES=3, LONG_TICKS=8, NUM_MODES=3.
1. Reset, then KEY=2'b11 for 200 clocks -> ssflag=0, mode=0, no strobes.
2. KEY[0] low for 40 clocks then high, from STOP -> key_press[0] single pulse, ssflag 0->2. Repeat -> ssflag 2->1. Repeat -> 1->2.
3. In RUN, KEY[1] low for 20 clocks (5 ticks < LONG) then release -> exactly one lap_pulse after the release debounce, ssflag stays 2. In PAUSE, same stimulus -> clear_pulse, ssflag=0.
4. KEY[1] held for 60 clocks in RUN -> ssflag=3 after 8 ticks held, no lap_pulse on release. Then three k0 presses -> mode 0->1->2->0. A short k1 press -> ssflag=0 plus clear_pulse, mode retained.
5. KEY[0] glitch low for 6 clocks (< 3 ticks) -> no key_press, ssflag unchanged. Bounce pattern 1,0,1,0 then stable 0 -> exactly one press pulse.
6. Assert RST mid-RUN with KEY[0] held, release RST -> ssflag=0 immediately, no spurious press until debounce completes (key_press[0] then pulses once, ssflag->2).
